// File: rtl/mcb_port_responder_if.sv
// MCB user port 0 bus bundle: command, write-data and read-data FIFO
// signals plus calibration status, grouped for the client (master) and
// the memory responder (slave).
interface mcb_port_responder_if;
    logic         c3_calib_done;

    logic         c3_p0_cmd_en;
    logic [2:0]   c3_p0_cmd_instr;
    logic [5:0]   c3_p0_cmd_bl;
    logic [29:0]  c3_p0_cmd_byte_addr;
    logic         c3_p0_cmd_empty;
    logic         c3_p0_cmd_full;

    logic         c3_p0_wr_en;
    logic [127:0] c3_p0_wr_data;
    logic [15:0]  c3_p0_wr_mask;
    logic         c3_p0_wr_empty;
    logic         c3_p0_wr_full;
    logic [6:0]   c3_p0_wr_count;
    logic         c3_p0_wr_underrun;
    logic         c3_p0_wr_error;

    logic         c3_p0_rd_en;
    logic [127:0] c3_p0_rd_data;
    logic         c3_p0_rd_empty;
    logic         c3_p0_rd_full;
    logic [6:0]   c3_p0_rd_count;
    logic         c3_p0_rd_overflow;
    logic         c3_p0_rd_error;

    modport master (
        input  c3_calib_done,
        output c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        input  c3_p0_cmd_empty, c3_p0_cmd_full,
        output c3_p0_wr_en, c3_p0_wr_data, c3_p0_wr_mask,
        input  c3_p0_wr_empty, c3_p0_wr_full, c3_p0_wr_count, c3_p0_wr_underrun, c3_p0_wr_error,
        output c3_p0_rd_en,
        input  c3_p0_rd_data, c3_p0_rd_empty, c3_p0_rd_full, c3_p0_rd_count,
        input  c3_p0_rd_overflow, c3_p0_rd_error
    );

    modport slave (
        output c3_calib_done,
        input  c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        output c3_p0_cmd_empty, c3_p0_cmd_full,
        input  c3_p0_wr_en, c3_p0_wr_data, c3_p0_wr_mask,
        output c3_p0_wr_empty, c3_p0_wr_full, c3_p0_wr_count, c3_p0_wr_underrun, c3_p0_wr_error,
        input  c3_p0_rd_en,
        output c3_p0_rd_data, c3_p0_rd_empty, c3_p0_rd_full, c3_p0_rd_count,
        output c3_p0_rd_overflow, c3_p0_rd_error
    );
endinterface

// File: rtl/mcb_port_responder.sv
// MCB user port 0 responder backed by on-chip RAM (128-bit words).
// Command, write and read FIFOs feed an in-order engine that performs
// one beat per cycle. RAM read is registered, so read data reaches the
// read FIFO one cycle after the beat that addressed it.
// Optional feature macro: MCB_RESP_RDLAT_EN (adds RD_LATENCY wait cycles
// before each read burst).
module mcb_port_responder #(
    parameter int ADDR_W       = 8,
    parameter int CMD_DEPTH    = 4,
    parameter int DATA_DEPTH   = 64,
    parameter int CALIB_CYCLES = 100,
    parameter int RD_LATENCY   = 8
) (
    input  logic                 c3_clk0,
    input  logic                 c3_rst0,
    mcb_port_responder_if.slave  p0
);
    localparam int CW   = $clog2(CMD_DEPTH);
    localparam int DW   = $clog2(DATA_DEPTH);
    localparam int CALW = $clog2(CALIB_CYCLES + 1);
    localparam int CMDW = 3 + 6 + ADDR_W;
    localparam logic [CW:0] CMD_FULL_CNT  = (CW+1)'(CMD_DEPTH);
    localparam logic [6:0]  DATA_FULL_CNT = 7'(DATA_DEPTH);

    typedef enum logic [2:0] {
        ST_CALIB  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_READ   = 3'd4
    } state_t;

    // storage (contents not reset; validity is tracked by the counts)
    logic [CMDW-1:0] cmd_mem_q [CMD_DEPTH];
    logic [143:0]    wr_mem_q  [DATA_DEPTH];
    logic [127:0]    rd_mem_q  [DATA_DEPTH];
    logic [127:0]    ram_q     [2**ADDR_W];
    logic [127:0]    rd_word_q;

    logic [CW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CW:0]   cmd_cnt_q, cmd_cnt_d;
    logic          cmd_empty_q, cmd_empty_d, cmd_full_q, cmd_full_d;
    logic [DW-1:0] wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [6:0]    wr_cnt_q, wr_cnt_d;
    logic          wr_empty_q, wr_empty_d, wr_full_q, wr_full_d;
    logic [DW-1:0] rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [6:0]    rd_cnt_q, rd_cnt_d;
    logic          rd_empty_q, rd_empty_d, rd_full_q, rd_full_d;

    state_t        state_q, state_d;
    logic [CALW-1:0] calib_cnt_q, calib_cnt_d;
    logic          calib_done_q, calib_done_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [6:0]    beats_q, beats_d;
    logic [127:0]  last_wd_q, last_wd_d;
    logic [15:0]   last_wm_q, last_wm_d;
    logic          rd_pipe_vld_q, rd_pipe_vld_d;
    logic          wr_underrun_q, wr_underrun_d, wr_error_q, wr_error_d;
    logic          rd_overflow_q, rd_overflow_d, rd_error_q, rd_error_d;
`ifdef MCB_RESP_RDLAT_EN
    localparam int LW = $clog2(RD_LATENCY + 1);
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
`endif

    logic cmd_push_s, cmd_pop_s, wr_push_s, wr_pop_s, rd_push_s, rd_pop_s;
    logic wr_uflow_s, ram_we_s, ram_re_s, unused_s;
    logic [127:0] ram_wdata_s;
    logic [15:0]  ram_wmask_s;
    logic [CMDW-1:0] cmd_head_s;
    logic [143:0] wr_head_s;

    assign cmd_head_s = cmd_mem_q[cmd_rp_q];
    assign wr_head_s  = wr_mem_q[wr_rp_q];

    // Command FIFO pointer/count bookkeeping; push while full is dropped
    always_comb begin
        cmd_push_s = p0.c3_p0_cmd_en & ~cmd_full_q;
        if (cmd_push_s) cmd_wp_d = cmd_wp_q + CW'(1);
        else            cmd_wp_d = cmd_wp_q;
        if (cmd_pop_s)  cmd_rp_d = cmd_rp_q + CW'(1);
        else            cmd_rp_d = cmd_rp_q;
        case ({cmd_push_s, cmd_pop_s})
            2'b10:   cmd_cnt_d = cmd_cnt_q + (CW+1)'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - (CW+1)'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
        cmd_empty_d = (cmd_cnt_d == (CW+1)'(0));
        cmd_full_d  = (cmd_cnt_d == CMD_FULL_CNT);
    end

    // Write-data FIFO bookkeeping; engine pops one word per write beat
    always_comb begin
        wr_push_s = p0.c3_p0_wr_en & ~wr_full_q;
        if (wr_push_s) wr_wp_d = wr_wp_q + DW'(1);
        else           wr_wp_d = wr_wp_q;
        if (wr_pop_s)  wr_rp_d = wr_rp_q + DW'(1);
        else           wr_rp_d = wr_rp_q;
        case ({wr_push_s, wr_pop_s})
            2'b10:   wr_cnt_d = wr_cnt_q + 7'd1;
            2'b01:   wr_cnt_d = wr_cnt_q - 7'd1;
            default: wr_cnt_d = wr_cnt_q;
        endcase
        wr_empty_d = (wr_cnt_d == 7'd0);
        wr_full_d  = (wr_cnt_d == DATA_FULL_CNT);
    end

    // Read-data FIFO bookkeeping; words arriving while full are lost
    always_comb begin
        rd_push_s = rd_pipe_vld_q & ~rd_full_q;
        rd_pop_s  = p0.c3_p0_rd_en & ~rd_empty_q;
        if (rd_push_s) rd_wp_d = rd_wp_q + DW'(1);
        else           rd_wp_d = rd_wp_q;
        if (rd_pop_s)  rd_rp_d = rd_rp_q + DW'(1);
        else           rd_rp_d = rd_rp_q;
        case ({rd_push_s, rd_pop_s})
            2'b10:   rd_cnt_d = rd_cnt_q + 7'd1;
            2'b01:   rd_cnt_d = rd_cnt_q - 7'd1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
        rd_empty_d = (rd_cnt_d == 7'd0);
        rd_full_d  = (rd_cnt_d == DATA_FULL_CNT);
    end

    // Sticky error/status flags
    always_comb begin
        wr_underrun_d = wr_underrun_q | wr_uflow_s;
        wr_error_d    = wr_error_q | wr_uflow_s | (p0.c3_p0_wr_en & wr_full_q);
        rd_overflow_d = rd_overflow_q | (rd_pipe_vld_q & rd_full_q);
        rd_error_d    = rd_error_q | (rd_pipe_vld_q & rd_full_q) | (p0.c3_p0_rd_en & rd_empty_q);
    end

    // Engine next-state: calibration countdown, command decode, burst beats
    always_comb begin
        state_d       = state_q;
        calib_cnt_d   = calib_cnt_q;
        calib_done_d  = calib_done_q;
        ptr_d         = ptr_q;
        beats_d       = beats_q;
        last_wd_d     = last_wd_q;
        last_wm_d     = last_wm_q;
        rd_pipe_vld_d = 1'b0;
        cmd_pop_s     = 1'b0;
        wr_pop_s      = 1'b0;
        wr_uflow_s    = 1'b0;
        ram_we_s      = 1'b0;
        ram_re_s      = 1'b0;
        ram_wdata_s   = last_wd_q;
        ram_wmask_s   = last_wm_q;
`ifdef MCB_RESP_RDLAT_EN
        lat_cnt_d     = lat_cnt_q;
`endif
        case (state_q)
            ST_CALIB: begin
                if (calib_cnt_q == CALW'(CALIB_CYCLES - 1)) begin
                    calib_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    calib_cnt_d  = calib_cnt_q + CALW'(1);
                end
            end
            ST_IDLE: begin
                if (!cmd_empty_q) begin
                    cmd_pop_s = 1'b1;
                    ptr_d     = cmd_head_s[ADDR_W-1:0];
                    beats_d   = {1'b0, cmd_head_s[ADDR_W +: 6]} + 7'd1;
                    case (cmd_head_s[CMDW-1 -: 3])
                        3'b000, 3'b010: state_d = ST_WRITE;
                        3'b001, 3'b011: begin
`ifdef MCB_RESP_RDLAT_EN
                            state_d   = ST_RDWAIT;
                            lat_cnt_d = LW'(0);
`else
                            state_d   = ST_READ;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                ram_we_s = 1'b1;
                if (!wr_empty_q) begin
                    wr_pop_s    = 1'b1;
                    ram_wdata_s = wr_head_s[127:0];
                    ram_wmask_s = wr_head_s[143:128];
                    last_wd_d   = wr_head_s[127:0];
                    last_wm_d   = wr_head_s[143:128];
                end else begin
                    wr_uflow_s  = 1'b1;
                end
                ptr_d   = ptr_q + ADDR_W'(1);
                beats_d = beats_q - 7'd1;
                if (beats_q == 7'd1) state_d = ST_IDLE;
                else                 state_d = ST_WRITE;
            end
`ifdef MCB_RESP_RDLAT_EN
            ST_RDWAIT: begin
                if (lat_cnt_q == LW'(RD_LATENCY - 1)) begin
                    state_d   = ST_READ;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                    state_d   = ST_RDWAIT;
                end
            end
`endif
            ST_READ: begin
                ram_re_s      = 1'b1;
                rd_pipe_vld_d = 1'b1;
                ptr_d         = ptr_q + ADDR_W'(1);
                beats_d       = beats_q - 7'd1;
                if (beats_q == 7'd1) state_d = ST_IDLE;
                else                 state_d = ST_READ;
            end
            default: state_d = ST_CALIB;
        endcase
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge c3_clk0) begin
        if (c3_rst0) begin
            cmd_wp_q <= CW'(0);  cmd_rp_q <= CW'(0);  cmd_cnt_q <= (CW+1)'(0);
            cmd_empty_q <= 1'b1; cmd_full_q <= 1'b0;
            wr_wp_q <= DW'(0);   wr_rp_q <= DW'(0);   wr_cnt_q <= 7'd0;
            wr_empty_q <= 1'b1;  wr_full_q <= 1'b0;
            rd_wp_q <= DW'(0);   rd_rp_q <= DW'(0);   rd_cnt_q <= 7'd0;
            rd_empty_q <= 1'b1;  rd_full_q <= 1'b0;
            state_q <= ST_CALIB; calib_cnt_q <= CALW'(0); calib_done_q <= 1'b0;
            ptr_q <= ADDR_W'(0); beats_q <= 7'd0;
            last_wd_q <= 128'd0; last_wm_q <= 16'd0; rd_pipe_vld_q <= 1'b0;
            wr_underrun_q <= 1'b0; wr_error_q <= 1'b0;
            rd_overflow_q <= 1'b0; rd_error_q <= 1'b0;
`ifdef MCB_RESP_RDLAT_EN
            lat_cnt_q <= LW'(0);
`endif
        end else begin
            cmd_wp_q <= cmd_wp_d; cmd_rp_q <= cmd_rp_d; cmd_cnt_q <= cmd_cnt_d;
            cmd_empty_q <= cmd_empty_d; cmd_full_q <= cmd_full_d;
            wr_wp_q <= wr_wp_d;   wr_rp_q <= wr_rp_d;   wr_cnt_q <= wr_cnt_d;
            wr_empty_q <= wr_empty_d; wr_full_q <= wr_full_d;
            rd_wp_q <= rd_wp_d;   rd_rp_q <= rd_rp_d;   rd_cnt_q <= rd_cnt_d;
            rd_empty_q <= rd_empty_d; rd_full_q <= rd_full_d;
            state_q <= state_d;   calib_cnt_q <= calib_cnt_d; calib_done_q <= calib_done_d;
            ptr_q <= ptr_d;       beats_q <= beats_d;
            last_wd_q <= last_wd_d; last_wm_q <= last_wm_d; rd_pipe_vld_q <= rd_pipe_vld_d;
            wr_underrun_q <= wr_underrun_d; wr_error_q <= wr_error_d;
            rd_overflow_q <= rd_overflow_d; rd_error_q <= rd_error_d;
`ifdef MCB_RESP_RDLAT_EN
            lat_cnt_q <= lat_cnt_d;
`endif
        end
    end

    // FIFO storage writes (only the word ADDR_W bits of the address are kept)
    always_ff @(posedge c3_clk0) begin
        if (cmd_push_s) cmd_mem_q[cmd_wp_q] <= {p0.c3_p0_cmd_instr, p0.c3_p0_cmd_bl,
                                                p0.c3_p0_cmd_byte_addr[ADDR_W+3:4]};
        if (wr_push_s)  wr_mem_q[wr_wp_q]   <= {p0.c3_p0_wr_mask, p0.c3_p0_wr_data};
        if (rd_push_s)  rd_mem_q[rd_wp_q]   <= rd_word_q;
    end

    // Backing RAM: byte-masked write (mask bit 1 keeps the byte), registered read
    always_ff @(posedge c3_clk0) begin
        if (ram_we_s) begin
            for (int b = 0; b < 16; b++) begin
                if (!ram_wmask_s[b]) ram_q[ptr_q][b*8 +: 8] <= ram_wdata_s[b*8 +: 8];
            end
        end
        if (ram_re_s) rd_word_q <= ram_q[ptr_q];
    end

    assign p0.c3_calib_done     = calib_done_q;
    assign p0.c3_p0_cmd_empty   = cmd_empty_q;
    assign p0.c3_p0_cmd_full    = cmd_full_q;
    assign p0.c3_p0_wr_empty    = wr_empty_q;
    assign p0.c3_p0_wr_full     = wr_full_q;
    assign p0.c3_p0_wr_count    = wr_cnt_q;
    assign p0.c3_p0_wr_underrun = wr_underrun_q;
    assign p0.c3_p0_wr_error    = wr_error_q;
    assign p0.c3_p0_rd_data     = rd_mem_q[rd_rp_q];
    assign p0.c3_p0_rd_empty    = rd_empty_q;
    assign p0.c3_p0_rd_full     = rd_full_q;
    assign p0.c3_p0_rd_count    = rd_cnt_q;
    assign p0.c3_p0_rd_overflow = rd_overflow_q;
    assign p0.c3_p0_rd_error    = rd_error_q;

    // byte-offset and above-memory address bits carry no meaning here
`ifdef MCB_RESP_RDLAT_EN
    assign unused_s = ^{p0.c3_p0_cmd_byte_addr[29:ADDR_W+4], p0.c3_p0_cmd_byte_addr[3:0]};
`else
    assign unused_s = ^{p0.c3_p0_cmd_byte_addr[29:ADDR_W+4], p0.c3_p0_cmd_byte_addr[3:0],
                        (RD_LATENCY > 0)};
`endif
endmodule

// File: tb/tb_mcb_port_responder.sv
// Bench for mcb_port_responder: a word-array model of the memory predicts
// every read word at issue time; a monitor drains the read FIFO and
// compares against the expectation queue.
module tb_mcb_port_responder;
    localparam int CALIB = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcb_port_responder_if p0();

    mcb_port_responder #(
        .ADDR_W(8), .CMD_DEPTH(4), .DATA_DEPTH(64), .CALIB_CYCLES(CALIB), .RD_LATENCY(8)
    ) dut (
        .c3_clk0(clk), .c3_rst0(rst), .p0(p0)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [127:0] mem_m [256];
    logic [127:0] exp_q [$];
    logic [127:0] wbuf [64];
    logic [15:0]  wmsk [64];
    logic         mon_en = 1'b0;

    localparam logic [24:0] RESET_FLAGS = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0,
                                           1'b1, 1'b0, 7'd0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] flags();
        return {p0.c3_calib_done, p0.c3_p0_cmd_empty, p0.c3_p0_cmd_full,
                p0.c3_p0_wr_empty, p0.c3_p0_wr_full, p0.c3_p0_wr_count,
                p0.c3_p0_wr_underrun, p0.c3_p0_wr_error,
                p0.c3_p0_rd_empty, p0.c3_p0_rd_full, p0.c3_p0_rd_count,
                p0.c3_p0_rd_overflow, p0.c3_p0_rd_error};
    endfunction

    function automatic logic [127:0] rword();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [29:0] raddr();
        return {18'($urandom), 8'($urandom), 4'($urandom)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        int t = 0;
        while (p0.c3_p0_cmd_full && t < 3000) begin tick(); t++; end
        if (t >= 3000) begin n_cmp++; n_fail++; $display("FAIL cmd_full_timeout: full=1 required 0"); end
        p0.c3_p0_cmd_en = 1'b1; p0.c3_p0_cmd_instr = instr;
        p0.c3_p0_cmd_bl = bl;   p0.c3_p0_cmd_byte_addr = addr;
        tick();
        p0.c3_p0_cmd_en = 1'b0;
    endtask

    task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
        int t = 0;
        while (p0.c3_p0_wr_full && t < 3000) begin tick(); t++; end
        if (t >= 3000) begin n_cmp++; n_fail++; $display("FAIL wr_full_timeout: full=1 required 0"); end
        p0.c3_p0_wr_en = 1'b1; p0.c3_p0_wr_data = d; p0.c3_p0_wr_mask = m;
        tick();
        p0.c3_p0_wr_en = 1'b0;
    endtask

    // queue wbuf/wmsk words then the command; model applies unmasked bytes
    task automatic do_write(input logic [2:0] instr, input int bl, input logic [29:0] addr);
        int w = int'(addr[11:4]);
        for (int i = 0; i <= bl; i++) begin
            push_wr(wbuf[i], wmsk[i]);
            for (int b = 0; b < 16; b++)
                if (!wmsk[i][b]) mem_m[(w + i) % 256][b*8 +: 8] = wbuf[i][b*8 +: 8];
        end
        push_cmd(instr, 6'(bl), addr);
    endtask

    task automatic do_read(input logic [2:0] instr, input int bl, input logic [29:0] addr);
        int w = int'(addr[11:4]);
        for (int i = 0; i <= bl; i++) exp_q.push_back(mem_m[(w + i) % 256]);
        push_cmd(instr, 6'(bl), addr);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !p0.c3_p0_cmd_empty) && t < 20000) begin tick(); t++; end
        if (t >= 20000) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
        end
        repeat (80) tick();
    endtask

    // monitor: pop the read FIFO whenever it shows a word and compare in order
    initial begin
        p0.c3_p0_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && p0.c3_p0_rd_empty === 1'b0) begin
                p0.c3_p0_rd_en = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no word", p0.c3_p0_rd_data);
                end else begin
                    check("rd_data", p0.c3_p0_rd_data, exp_q.pop_front());
                end
            end else begin
                p0.c3_p0_rd_en = 1'b0;
            end
        end
    end

    initial begin
        logic [127:0] w1;
        rst = 1'b1;
        p0.c3_p0_cmd_en = 1'b0; p0.c3_p0_cmd_instr = 3'd0; p0.c3_p0_cmd_bl = 6'd0;
        p0.c3_p0_cmd_byte_addr = 30'd0;
        p0.c3_p0_wr_en = 1'b0; p0.c3_p0_wr_data = 128'd0; p0.c3_p0_wr_mask = 16'd0;
        repeat (3) tick();
        check("reset_flags", 128'(flags()), 128'(RESET_FLAGS));
        rst = 1'b0;
        for (int k = 1; k <= CALIB; k++) begin
            tick();
            if (k == CALIB - 1) check("calib_early", 128'(p0.c3_calib_done), 128'd0);
            if (k == CALIB)     check("calib_rise", 128'(p0.c3_calib_done), 128'd1);
        end
        mon_en = 1'b1;

        // preload every word so any later read has a known model value
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 64; i++) begin wbuf[i] = rword(); wmsk[i] = 16'h0000; end
            do_write(3'b000, 63, 30'(c * 1024));
        end

        // single-word write/read of the reference pattern
        wbuf[0] = 128'hcafebabe_12345678_AA55AA55_55AA55AA; wmsk[0] = 16'h0000;
        do_write(3'b000, 0, 30'h0);
        do_read(3'b001, 0, 30'h0);
        drain();
        check("basic_errors", 128'({p0.c3_p0_wr_error, p0.c3_p0_rd_error}), 128'd0);

        // burst crossing the top of memory: words 255,0,1,2
        for (int i = 0; i < 4; i++) begin wbuf[i] = rword(); wmsk[i] = 16'h0000; end
        do_write(3'b010, 3, 30'h0FF0);
        do_read(3'b011, 3, 30'h0FF0);
        do_read(3'b001, 0, 30'h0);

        // byte mask over an all-ones word
        wbuf[0] = {4{32'hFFFF_FFFF}}; wmsk[0] = 16'h0000;
        do_write(3'b000, 0, 30'h0500);
        wbuf[0] = rword(); wmsk[0] = 16'h000F;
        do_write(3'b000, 0, 30'h0500);
        do_read(3'b001, 0, 30'h0500);
        drain();

        // randomized mix of writes, reads and no-ops
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 9);
            int bl = $urandom_range(0, 15);
            logic [29:0] a = raddr();
            if (kind < 4) begin
                for (int i = 0; i <= bl; i++) begin
                    wbuf[i] = rword();
                    wmsk[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
                end
                do_write((kind % 2 == 0) ? 3'b000 : 3'b010, bl, a);
            end else if (kind < 8) begin
                do_read((kind % 2 == 0) ? 3'b001 : 3'b011, bl, a);
            end else begin
                push_cmd(3'($urandom_range(4, 7)), 6'(bl), a);
            end
        end
        drain();
        check("random_sticky", 128'({p0.c3_p0_wr_underrun, p0.c3_p0_wr_error,
                                     p0.c3_p0_rd_overflow, p0.c3_p0_rd_error}), 128'd0);

        // two-beat write with only one queued word: second beat repeats the first
        w1 = rword();
        push_wr(w1, 16'h0000);
        push_cmd(3'b000, 6'd1, 30'h0200);
        mem_m[32] = w1;
        mem_m[33] = w1;
        drain();
        check("underrun_flags", 128'({p0.c3_p0_wr_underrun, p0.c3_p0_wr_error}), 128'h3);
        do_read(3'b001, 1, 30'h0200);
        drain();

        // fill the read FIFO with nobody popping, then one more word overflows
        mon_en = 1'b0;
        repeat (2) tick();
        do_read(3'b001, 63, 30'h0);
        push_cmd(3'b001, 6'd0, 30'h0010);
        repeat (100) tick();
        check("rd_count_full", 128'(p0.c3_p0_rd_count), 128'd64);
        check("overflow_flags", 128'({p0.c3_p0_rd_full, p0.c3_p0_rd_overflow, p0.c3_p0_rd_error}),
              128'h7);
        mon_en = 1'b1;
        drain();

        // reset clears sticky state; then overfill the write FIFO during calibration
        rst = 1'b1;
        repeat (2) tick();
        check("reset_again", 128'(flags()), 128'(RESET_FLAGS));
        rst = 1'b0;
        for (int i = 0; i < 65; i++) begin
            p0.c3_p0_wr_en = 1'b1; p0.c3_p0_wr_data = rword(); p0.c3_p0_wr_mask = 16'h0000;
            tick();
        end
        p0.c3_p0_wr_en = 1'b0;
        tick();
        check("wr_count_full", 128'(p0.c3_p0_wr_count), 128'd64);
        check("wr_full_flags", 128'({p0.c3_p0_wr_full, p0.c3_p0_wr_empty, p0.c3_p0_wr_error,
                                     p0.c3_p0_wr_underrun}), 128'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
